// File: rtl/xregf_dump_ctrl_if.sv
// Bus bundle of the register-file dump engine: the parallel port toward xtop and
// the valid/ready output stream toward the consumer.
interface xregf_dump_ctrl_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 4
);
    logic [ADDR_W-1:0] par_addr;
    logic              par_we;
    logic [DATA_W-1:0] par_in;
    logic [DATA_W-1:0] par_out;
    logic [DATA_W-1:0] out_data;
    logic              out_valid;
    logic              out_ready;
    logic              out_last;

    modport master (
        output par_addr, par_we, par_in, out_data, out_valid, out_last,
        input  par_out, out_ready
    );

    modport slave (
        input  par_addr, par_we, par_in, out_data, out_valid, out_last,
        output par_out, out_ready
    );
endinterface

// File: rtl/xregf_dump_ctrl.sv
// Post-run register-file dump engine: on a trap rising edge it sweeps every register
// entry of xtop and streams the words out. Define DUMP_CSUM_EN to append an XOR checksum word.
module xregf_dump_ctrl #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 4,
    parameter int SETTLE = 10,
    parameter int RD_LAT = 1
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              trap_i,
    xregf_dump_ctrl_if.master bus,
    output logic              busy_o,
    output logic              done_o
);
    localparam int                CNT_W       = (SETTLE > 1) ? $clog2(SETTLE) : 1;
    localparam int                SETTLE_M1   = (SETTLE > 0) ? SETTLE - 1 : 0;
    localparam logic [CNT_W-1:0]  SETTLE_LOAD = CNT_W'(SETTLE_M1);
    localparam logic [1:0]        LAT_LOAD    = 2'(RD_LAT);
    localparam logic [ADDR_W-1:0] IDX_LAST    = {ADDR_W{1'b1}};

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_SETTLE = 3'd1,
        ST_ADDR   = 3'd2,
        ST_CAPT   = 3'd3,
        ST_SEND   = 3'd4,
`ifdef DUMP_CSUM_EN
        ST_CSUM   = 3'd5,
`endif
        ST_DONE   = 3'd6
    } state_e;

    state_e            state_q, state_d;
    logic              trap_q;
    logic              armed_q;
    logic [ADDR_W-1:0] idx_q, idx_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [1:0]        lat_q, lat_d;
    logic [ADDR_W-1:0] par_addr_q, par_addr_d;
    logic [DATA_W-1:0] out_data_q, out_data_d;
    logic              out_valid_q, out_valid_d;
    logic              out_last_q, out_last_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              start_s;
`ifdef DUMP_CSUM_EN
    logic [DATA_W-1:0] csum_q, csum_d;
`endif

    // armed_q blocks a trap that is already high when reset releases from counting as an edge
    assign start_s = trap_i & ~trap_q & armed_q;

    // Next-state and output-register logic of the dump sequencer
    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        cnt_d       = cnt_q;
        lat_d       = lat_q;
        par_addr_d  = par_addr_q;
        out_data_d  = out_data_q;
        out_valid_d = out_valid_q;
        out_last_d  = out_last_q;
`ifdef DUMP_CSUM_EN
        csum_d      = csum_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (start_s) begin
`ifdef DUMP_CSUM_EN
                    csum_d = {DATA_W{1'b0}};
`endif
                    cnt_d = SETTLE_LOAD;
                    lat_d = LAT_LOAD;
                    if (SETTLE == 0) begin
                        state_d = ST_ADDR;
                    end else begin
                        state_d = ST_SETTLE;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_SETTLE: begin
                if (cnt_q == {CNT_W{1'b0}}) begin
                    lat_d   = LAT_LOAD;
                    state_d = ST_ADDR;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            ST_ADDR: begin
                par_addr_d = idx_q;
                if (lat_q == 2'd0) begin
                    state_d = ST_CAPT;
                end else begin
                    lat_d = lat_q - 2'd1;
                end
            end
            ST_CAPT: begin
                out_data_d  = bus.par_out;
                out_valid_d = 1'b1;
`ifdef DUMP_CSUM_EN
                csum_d      = csum_q ^ bus.par_out;
                out_last_d  = 1'b0;
`else
                out_last_d  = (idx_q == IDX_LAST);
`endif
                state_d     = ST_SEND;
            end
            ST_SEND: begin
                if (out_valid_q && bus.out_ready) begin
                    out_valid_d = 1'b0;
                    out_last_d  = 1'b0;
                    if (idx_q == IDX_LAST) begin
`ifdef DUMP_CSUM_EN
                        // Checksum word is presented straight away; csum_q already holds the last word
                        out_data_d  = csum_q;
                        out_valid_d = 1'b1;
                        out_last_d  = 1'b1;
                        state_d     = ST_CSUM;
`else
                        state_d     = ST_DONE;
`endif
                    end else begin
                        idx_d   = idx_q + ADDR_W'(1);
                        lat_d   = LAT_LOAD;
                        state_d = ST_ADDR;
                    end
                end else begin
                    state_d = ST_SEND;
                end
            end
`ifdef DUMP_CSUM_EN
            ST_CSUM: begin
                if (out_valid_q && bus.out_ready) begin
                    out_valid_d = 1'b0;
                    out_last_d  = 1'b0;
                    state_d     = ST_DONE;
                end else begin
                    state_d = ST_CSUM;
                end
            end
`endif
            ST_DONE: begin
                if (!trap_i) begin
                    idx_d   = {ADDR_W{1'b0}};
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_DONE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        busy_d = (state_d != ST_IDLE) && (state_d != ST_DONE);
        done_d = (state_d == ST_DONE);
    end

    // State and output registers with synchronous reset
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= ST_IDLE;
            trap_q      <= 1'b0;
            armed_q     <= ~trap_i;
            idx_q       <= {ADDR_W{1'b0}};
            cnt_q       <= {CNT_W{1'b0}};
            lat_q       <= 2'd0;
            par_addr_q  <= {ADDR_W{1'b0}};
            out_data_q  <= {DATA_W{1'b0}};
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
`ifdef DUMP_CSUM_EN
            csum_q      <= {DATA_W{1'b0}};
`endif
        end else begin
            state_q     <= state_d;
            trap_q      <= trap_i;
            armed_q     <= armed_q | ~trap_i;
            idx_q       <= idx_d;
            cnt_q       <= cnt_d;
            lat_q       <= lat_d;
            par_addr_q  <= par_addr_d;
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
            out_last_q  <= out_last_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
`ifdef DUMP_CSUM_EN
            csum_q      <= csum_d;
`endif
        end
    end

    assign bus.par_addr  = par_addr_q;
    assign bus.par_we    = 1'b0;
    assign bus.par_in    = {DATA_W{1'b0}};
    assign bus.out_data  = out_data_q;
    assign bus.out_valid = out_valid_q;
    assign bus.out_last  = out_last_q;
    assign busy_o        = busy_q;
    assign done_o        = done_q;
endmodule

// File: tb/tb_xregf_dump_ctrl.sv
// Directed self-checking bench for xregf_dump_ctrl: two instances (slow settle / fast
// settle with long read latency) each paired with a small xtop register-file model.
`timescale 1ns/1ps
module tb_xregf_dump_ctrl;
    localparam int DATA_W   = 32;
    localparam int ADDR_W   = 4;
    localparam int NREG     = 16;
`ifdef DUMP_CSUM_EN
    localparam int NWORDS   = NREG + 1;
`else
    localparam int NWORDS   = NREG;
`endif
    localparam int SETTLE_A = 10;
    localparam int RD_LAT_A = 1;
    localparam int SETTLE_B = 0;
    localparam int RD_LAT_B = 3;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        trap_a = 1'b0;
    logic        trap_b = 1'b0;
    logic        busy_a, done_a, busy_b, done_b;
    int          checks = 0;
    int          errors = 0;
    logic [31:0] mem [NREG];
    logic [31:0] pat_mul;
    logic [31:0] b_pipe1, b_pipe2;

    xregf_dump_ctrl_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) if_a ();
    xregf_dump_ctrl_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) if_b ();

    xregf_dump_ctrl #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .SETTLE(SETTLE_A), .RD_LAT(RD_LAT_A)) dut_a (
        .clk_i(clk), .rst_i(rst), .trap_i(trap_a), .bus(if_a), .busy_o(busy_a), .done_o(done_a)
    );
    xregf_dump_ctrl #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .SETTLE(SETTLE_B), .RD_LAT(RD_LAT_B)) dut_b (
        .clk_i(clk), .rst_i(rst), .trap_i(trap_b), .bus(if_b), .busy_o(busy_b), .done_o(done_b)
    );

    always #5 clk = ~clk;

    // xtop register-file read models with one and three cycles of read latency
    always_ff @(posedge clk) begin
        if_a.par_out <= mem[if_a.par_addr];
        b_pipe1      <= mem[if_b.par_addr];
        b_pipe2      <= b_pipe1;
        if_b.par_out <= b_pipe2;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached, required finish before it");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic fill(input logic [31:0] mul);
        pat_mul = mul;
        for (int i = 0; i < NREG; i++) mem[i] = 32'(i) * mul;
    endtask

    function automatic logic [31:0] exp_word(input int k);
        logic [31:0] acc;
        acc = 32'h0000_0000;
        if (k < NREG) return 32'(k) * pat_mul;
        for (int i = 0; i < NREG; i++) acc = acc ^ (32'(i) * pat_mul);
        return acc;
    endfunction

    function automatic logic v_of(input bit use_b);
        return use_b ? if_b.out_valid : if_a.out_valid;
    endfunction
    function automatic logic hs_of(input bit use_b);
        return use_b ? (if_b.out_valid & if_b.out_ready) : (if_a.out_valid & if_a.out_ready);
    endfunction
    function automatic logic [31:0] d_of(input bit use_b);
        return use_b ? if_b.out_data : if_a.out_data;
    endfunction
    function automatic logic l_of(input bit use_b);
        return use_b ? if_b.out_last : if_a.out_last;
    endfunction
    function automatic logic busy_of(input bit use_b);
        return use_b ? busy_b : busy_a;
    endfunction
    function automatic logic done_of(input bit use_b);
        return use_b ? done_b : done_a;
    endfunction

    task automatic set_trap(input bit use_b, input logic val);
        if (use_b) trap_b = val;
        else trap_a = val;
    endtask
    task automatic set_ready(input bit use_b, input logic val);
        if (use_b) if_b.out_ready = val;
        else if_a.out_ready = val;
    endtask

    // Waits (bounded) for a handshake, returns the word and how many cycles it waited
    task automatic recv(input bit use_b, output logic [31:0] d, output logic l,
                        output int waited, output bit tmo);
        waited = 0;
        tmo    = 1'b0;
        d      = 32'h0;
        l      = 1'b0;
        while (!hs_of(use_b) && waited < 200) begin
            tick();
            waited++;
        end
        if (!hs_of(use_b)) begin
            tmo = 1'b1;
            return;
        end
        d = d_of(use_b);
        l = l_of(use_b);
        tick();
    endtask

    task automatic test_full_dump(input bit use_b, input string tag, input int exp_first, input int exp_gap);
        logic [31:0] d;
        logic        l;
        int          w;
        bit          tmo;
        int          n;
        set_ready(use_b, 1'b1);
        set_trap(use_b, 1'b1);
        n = 0;
        while (!v_of(use_b) && n < 400) begin
            tick();
            n++;
            if (n == 1) set_trap(use_b, 1'b0);
        end
        checks++;
        if (n !== exp_first) begin
            errors++;
            $display("FAIL %s_first_latency: got %0d cycles, expected %0d", tag, n, exp_first);
        end
        checks++;
        if (busy_of(use_b) !== 1'b1) begin
            errors++;
            $display("FAIL %s_busy: got %b, expected 1", tag, busy_of(use_b));
        end
        for (int k = 0; k < NWORDS; k++) begin
            recv(use_b, d, l, w, tmo);
            checks++;
            if (tmo) begin
                errors++;
                $display("FAIL %s_timeout word %0d: no handshake, expected one", tag, k);
                return;
            end
            checks++;
            if (d !== exp_word(k)) begin
                errors++;
                $display("FAIL %s_data word %0d: got %h, expected %h", tag, k, d, exp_word(k));
            end
            checks++;
            if (l !== ((k == NWORDS - 1) ? 1'b1 : 1'b0)) begin
                errors++;
                $display("FAIL %s_last word %0d: got %b, expected %b", tag, k, l, (k == NWORDS - 1));
            end
            if (k > 0 && k < NREG) begin
                checks++;
                if (w !== exp_gap) begin
                    errors++;
                    $display("FAIL %s_gap word %0d: waited %0d, expected %0d", tag, k, w, exp_gap);
                end
            end
        end
        checks++;
        if ({done_of(use_b), busy_of(use_b)} !== 2'b10) begin
            errors++;
            $display("FAIL %s_done: got done=%b busy=%b, expected done=1 busy=0", tag, done_of(use_b), busy_of(use_b));
        end
        tick();
        checks++;
        if (done_of(use_b) !== 1'b0) begin
            errors++;
            $display("FAIL %s_idle: got done=%b, expected 0 after trap low", tag, done_of(use_b));
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        checks++;
        if ({if_a.par_addr, if_a.par_we, if_a.par_in, if_a.out_data, if_a.out_valid, if_a.out_last, busy_a, done_a} !== 73'd0) begin
            errors++;
            $display("FAIL reset_a: got addr=%h we=%b in=%h data=%h v=%b l=%b busy=%b done=%b, expected all 0",
                     if_a.par_addr, if_a.par_we, if_a.par_in, if_a.out_data, if_a.out_valid, if_a.out_last, busy_a, done_a);
        end
        checks++;
        if ({if_b.par_addr, if_b.par_we, if_b.par_in, if_b.out_data, if_b.out_valid, if_b.out_last, busy_b, done_b} !== 73'd0) begin
            errors++;
            $display("FAIL reset_b: got addr=%h we=%b in=%h data=%h v=%b l=%b busy=%b done=%b, expected all 0",
                     if_b.par_addr, if_b.par_we, if_b.par_in, if_b.out_data, if_b.out_valid, if_b.out_last, busy_b, done_b);
        end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_dump_basic();
        fill(32'h11);
        test_full_dump(1'b0, "t1", SETTLE_A + RD_LAT_A + 3, RD_LAT_A + 2);
    endtask

    task automatic test_backpressure();
        logic [31:0] d;
        logic        l;
        int          w;
        bit          tmo;
        int          n;
        if_a.out_ready = 1'b1;
        trap_a = 1'b1;
        tick();
        trap_a = 1'b0;
        for (int k = 0; k < 3; k++) begin
            recv(1'b0, d, l, w, tmo);
            checks++;
            if (tmo || d !== exp_word(k)) begin
                errors++;
                $display("FAIL t2_pre word %0d: got %h (timeout=%b), expected %h", k, d, tmo, exp_word(k));
            end
        end
        if_a.out_ready = 1'b0;
        n = 0;
        while (!if_a.out_valid && n < 200) begin
            tick();
            n++;
        end
        for (int i = 0; i < 7; i++) begin
            checks++;
            if ({if_a.out_valid, if_a.par_addr, if_a.out_data} !== {1'b1, 4'd3, 32'h0000_0033}) begin
                errors++;
                $display("FAIL t2_stall cycle %0d: got v=%b addr=%h data=%h, expected v=1 addr=3 data=00000033",
                         i, if_a.out_valid, if_a.par_addr, if_a.out_data);
            end
            tick();
        end
        if_a.out_ready = 1'b1;
        for (int k = 3; k < NWORDS; k++) begin
            recv(1'b0, d, l, w, tmo);
            checks++;
            if (tmo || d !== exp_word(k) || l !== ((k == NWORDS - 1) ? 1'b1 : 1'b0)) begin
                errors++;
                $display("FAIL t2_post word %0d: got %h last=%b (timeout=%b), expected %h last=%b",
                         k, d, l, tmo, exp_word(k), (k == NWORDS - 1));
            end
        end
        checks++;
        if (done_a !== 1'b1) begin
            errors++;
            $display("FAIL t2_done: got %b, expected 1", done_a);
        end
        tick();
    endtask

    task automatic test_reset_mid_dump();
        logic [31:0] d;
        logic        l;
        int          w;
        bit          tmo;
        int          n;
        bit          active;
        if_a.out_ready = 1'b1;
        trap_a = 1'b1;
        tick();
        trap_a = 1'b0;
        for (int k = 0; k < 8; k++) begin
            recv(1'b0, d, l, w, tmo);
            checks++;
            if (tmo || d !== exp_word(k)) begin
                errors++;
                $display("FAIL t3_pre word %0d: got %h (timeout=%b), expected %h", k, d, tmo, exp_word(k));
            end
        end
        n = 0;
        while (!if_a.out_valid && n < 200) begin
            tick();
            n++;
        end
        checks++;
        if (if_a.out_data !== exp_word(8)) begin
            errors++;
            $display("FAIL t3_word8: got %h, expected %h", if_a.out_data, exp_word(8));
        end
        rst = 1'b1;
        tick();
        checks++;
        if ({if_a.par_addr, if_a.par_we, if_a.par_in, if_a.out_data, if_a.out_valid, if_a.out_last, busy_a, done_a} !== 73'd0) begin
            errors++;
            $display("FAIL t3_abort: got addr=%h data=%h v=%b l=%b busy=%b done=%b, expected all 0",
                     if_a.par_addr, if_a.out_data, if_a.out_valid, if_a.out_last, busy_a, done_a);
        end
        rst = 1'b0;
        active = 1'b0;
        for (int i = 0; i < 20; i++) begin
            tick();
            active = active | busy_a | if_a.out_valid;
        end
        checks++;
        if (active !== 1'b0) begin
            errors++;
            $display("FAIL t3_quiet: got activity=%b after reset, expected 0", active);
        end
        test_full_dump(1'b0, "t3_restart", SETTLE_A + RD_LAT_A + 3, RD_LAT_A + 2);
    endtask

    task automatic test_trap_high_at_reset();
        bit active;
        trap_a = 1'b1;
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        active = 1'b0;
        for (int i = 0; i < 30; i++) begin
            tick();
            active = active | busy_a | if_a.out_valid | done_a;
        end
        checks++;
        if (active !== 1'b0) begin
            errors++;
            $display("FAIL t4_no_dump: got activity=%b with trap held high, expected 0", active);
        end
        trap_a = 1'b0;
        tick();
        test_full_dump(1'b0, "t4", SETTLE_A + RD_LAT_A + 3, RD_LAT_A + 2);
    endtask

    task automatic test_fast_config();
        // 6 samples after raising trap is 5 edges after the edge that first samples it high
        test_full_dump(1'b1, "t5", SETTLE_B + RD_LAT_B + 3, RD_LAT_B + 2);
    endtask

`ifdef DUMP_CSUM_EN
    task automatic test_csum();
        fill(32'h1);
        test_full_dump(1'b0, "t6", SETTLE_A + RD_LAT_A + 3, RD_LAT_A + 2);
    endtask
`endif

    initial begin
        if_a.out_ready = 1'b0;
        if_b.out_ready = 1'b0;
        fill(32'h11);
        test_reset();
        test_dump_basic();
        test_backpressure();
        test_reset_mid_dump();
        test_trap_high_at_reset();
        test_fast_config();
`ifdef DUMP_CSUM_EN
        test_csum();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
